gcd_xcel_responder: RTL and testbench

- Responder end of the host GCD request/response protocol.
- Accepts one packed request {a, b} over a val/rdy input and computes gcd(a, b) with iterative Euclid subtract/swap.
- Returns the result over a val/rdy output.
- Sits behind the host software shim as the unit the test source drives and the test sink checks; one transaction in flight at a time.

---
 rtl/gcd_xcel_responder_if.sv | 30 +++
 rtl/gcd_xcel_responder.sv | 81 ++++++++
 tb/tb_gcd_xcel_responder.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_xcel_responder_if.sv
// Request/response val/rdy bundle between the host shim and the GCD responder.
// Master drives requests and response-ready; slave answers.
interface gcd_xcel_responder_if #(
   parameter int p_nbits = 16
);
   logic                   req_val;
   logic                   req_rdy;
   logic [2*p_nbits-1:0]   req_msg;
   logic                   resp_val;
   logic                   resp_rdy;
   logic [p_nbits-1:0]     resp_msg;

   modport master (
      output req_val,
      output req_msg,
      output resp_rdy,
      input  req_rdy,
      input  resp_val,
      input  resp_msg
   );

   modport slave (
      input  req_val,
      input  req_msg,
      input  resp_rdy,
      output req_rdy,
      output resp_val,
      output resp_msg
   );
endinterface

// File: rtl/gcd_xcel_responder.sv
// GCD responder: accepts {a, b}, runs Euclid subtract/swap, returns gcd.
// One transaction in flight; response and next request may share an edge.
module gcd_xcel_responder #(
   parameter int p_nbits = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   gcd_xcel_responder_if.slave   xif,
   output logic                  busy
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [p_nbits-1:0] a_q, a_d;
   logic [p_nbits-1:0] b_q, b_d;
   logic               rdy;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      a_d          = a_q;
      b_d          = b_q;
      rdy          = 1'b0;
      xif.resp_val = 1'b0;
      xif.resp_msg = '0;
      unique case (state_q)
         IDLE: begin
            rdy = 1'b1;
            if (xif.req_val) begin
               a_d     = xif.req_msg[2*p_nbits-1:p_nbits];
               b_d     = xif.req_msg[p_nbits-1:0];
               state_d = CALC;
            end
         end
         CALC: begin
            if (a_q < b_q) begin
               a_d = b_q;
               b_d = a_q;
            end else if (b_q != '0) begin
               a_d = a_q - b_q;
            end else begin
               state_d = DONE;
            end
         end
         DONE: begin
            xif.resp_val = 1'b1;
            xif.resp_msg = a_q;
            // Ready for a new request exactly when the result leaves.
            rdy = xif.resp_rdy;
            if (xif.resp_rdy) begin
               if (xif.req_val) begin
                  a_d     = xif.req_msg[2*p_nbits-1:p_nbits];
                  b_d     = xif.req_msg[p_nbits-1:0];
                  state_d = CALC;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign xif.req_rdy = rdy & reset;
   assign busy        = (state_q == CALC) || (state_q == DONE);
endmodule

// File: tb/tb_gcd_xcel_responder.sv
// Randomized and directed bench for the GCD responder.
// Reference: modulo-based gcd plus cycle counts for chosen operands.
module tb_gcd_xcel_responder;
   localparam int NB = 16;

   logic clk;
   logic reset;
   logic busy;
   int   errors;
   int   checks;

   gcd_xcel_responder_if #(.p_nbits(NB)) xif ();

   gcd_xcel_responder #(.p_nbits(NB)) dut (
      .clk   (clk),
      .reset (reset),
      .xif   (xif),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [NB-1:0] ref_gcd(input logic [NB-1:0] a,
                                             input logic [NB-1:0] b);
      int unsigned x, y, t;
      x = a;
      y = b;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x[NB-1:0];
   endfunction

   task automatic do_req(input logic [NB-1:0] a, input logic [NB-1:0] b,
                         input logic [NB-1:0] exp_r, input int exp_n,
                         input string nm);
      int t;
      int cyc;
      xif.resp_rdy = 1'b1;
      @(negedge clk);
      xif.req_val = 1'b1;
      xif.req_msg = {a, b};
      #1;
      t = 0;
      while (!xif.req_rdy && t < 100) begin
         @(negedge clk);
         #1;
         t++;
      end
      checks++;
      if (xif.req_rdy !== 1'b1) begin
         errors++;
         $display("FAIL %s_accept: req_rdy=%b required 1", nm, xif.req_rdy);
      end
      @(posedge clk);
      #1;
      xif.req_val = 1'b0;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!xif.resp_val && cyc < 80000);
      if (exp_n >= 0) begin
         checks++;
         if (cyc !== exp_n + 1) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles required %0d",
                     nm, cyc, exp_n + 1);
         end
      end
      checks++;
      if (xif.resp_val !== 1'b1 || xif.resp_msg !== exp_r) begin
         errors++;
         $display("FAIL %s_result: val=%b msg=%h required val=1 msg=%h",
                  nm, xif.resp_val, xif.resp_msg, exp_r);
      end
      @(posedge clk);
      #1;
      checks++;
      if (xif.resp_val !== 1'b0) begin
         errors++;
         $display("FAIL %s_drain: resp_val=%b required 0", nm, xif.resp_val);
      end
   endtask

   task automatic test_reset();
      xif.req_val  = 1'b0;
      xif.req_msg  = '0;
      xif.resp_rdy = 1'b1;
      reset        = 1'b0;
      #12;
      checks++;
      if (xif.req_rdy !== 1'b0 || xif.resp_val !== 1'b0 ||
          xif.resp_msg !== '0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold: rdy=%b val=%b msg=%h busy=%b required 0 0 0 0",
                  xif.req_rdy, xif.resp_val, xif.resp_msg, busy);
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if (xif.req_rdy !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: rdy=%b busy=%b required 1 0",
                  xif.req_rdy, busy);
      end
   endtask

   task automatic test_reset_abort();
      int seen;
      @(negedge clk);
      xif.req_val = 1'b1;
      xif.req_msg = {16'hFFFF, 16'h0001};
      @(posedge clk);
      #1;
      xif.req_val = 1'b0;
      repeat (10) @(posedge clk);
      #3;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL abort_busy: busy=%b required 1", busy);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (xif.req_rdy !== 1'b0 || xif.resp_val !== 1'b0 ||
          xif.resp_msg !== '0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_async: rdy=%b val=%b msg=%h busy=%b required 0 0 0 0",
                  xif.req_rdy, xif.resp_val, xif.resp_msg, busy);
      end
      #3;
      reset = 1'b1;
      #1;
      checks++;
      if (xif.req_rdy !== 1'b1 || xif.resp_val !== 1'b0 ||
          xif.resp_msg !== '0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_release: rdy=%b val=%b msg=%h busy=%b required 1 0 0 0",
                  xif.req_rdy, xif.resp_val, xif.resp_msg, busy);
      end
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (xif.resp_val) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL abort_noresp: %0d response cycles required 0", seen);
      end
      do_req(16'h000F, 16'h0005, 16'h0005, -1, "after_reset");
   endtask

   task automatic test_latency();
      do_req(16'd15, 16'd5, 16'h0005, 5, "lat_15_5");
   endtask

   task automatic test_boundaries();
      do_req(16'd0, 16'd0, 16'd0, 1, "zero_zero");
      do_req(16'd0, 16'd7, 16'd7, 2, "zero_b");
      do_req(16'd9, 16'd0, 16'd9, 1, "a_zero");
      do_req(16'd21, 16'd21, 16'd21, 3, "a_eq_b");
      do_req(16'hFFFF, 16'hFFFF, 16'hFFFF, 3, "max_eq");
   endtask

   task automatic test_backpressure();
      int t;
      int xfers;
      int bad;
      xif.resp_rdy = 1'b0;
      @(negedge clk);
      xif.req_val = 1'b1;
      xif.req_msg = {16'd27, 16'd36};
      @(posedge clk);
      #1;
      xif.req_val = 1'b0;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!xif.resp_val && t < 200);
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (xif.resp_val !== 1'b1 || xif.resp_msg !== 16'h0009 ||
             xif.req_rdy !== 1'b0) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL stall_hold: %0d bad stall cycles, last val=%b msg=%h rdy=%b required 1 0009 0",
                  bad, xif.resp_val, xif.resp_msg, xif.req_rdy);
      end
      xif.resp_rdy = 1'b1;
      xfers = 0;
      repeat (5) begin
         #2;
         if (xif.resp_val && xif.resp_rdy) xfers++;
         @(posedge clk);
         @(negedge clk);
      end
      checks++;
      if (xfers !== 1) begin
         errors++;
         $display("FAIL stall_release: %0d transfers required 1", xfers);
      end
   endtask

   task automatic test_back_to_back();
      logic [NB-1:0] expq[$];
      logic [NB-1:0] a, b, k;
      int sent, rcvd, src_dly, snk_dly, cyc, b2b, bad;
      logic req_fire, resp_fire;
      sent    = 0;
      rcvd    = 0;
      src_dly = 0;
      snk_dly = 0;
      cyc     = 0;
      b2b     = 0;
      bad     = 0;
      xif.req_val = 1'b0;
      while (rcvd < 1000 && cyc < 90000) begin
         @(negedge clk);
         cyc++;
         if (!xif.req_val && sent < 1000) begin
            if (src_dly == 0) begin
               if ($urandom_range(0, 1) == 0) begin
                  a = 16'($urandom_range(0, 255));
                  b = 16'($urandom_range(0, 255));
               end else begin
                  k = 16'($urandom_range(0, 4095));
                  a = 16'($urandom_range(0, 15)) * k;
                  b = 16'($urandom_range(0, 15)) * k;
               end
               xif.req_val = 1'b1;
               xif.req_msg = {a, b};
            end else begin
               src_dly--;
            end
         end
         xif.resp_rdy = (snk_dly == 0);
         if (snk_dly != 0) snk_dly--;
         #2;
         req_fire  = xif.req_val && xif.req_rdy;
         resp_fire = xif.resp_val && xif.resp_rdy;
         if (resp_fire) begin
            if (expq.size() == 0) begin
               bad++;
               $display("FAIL stream_extra: response %h with nothing outstanding",
                        xif.resp_msg);
            end else if (xif.resp_msg !== expq[0]) begin
               bad++;
               $display("FAIL stream_%0d: got %h required %h",
                        rcvd, xif.resp_msg, expq[0]);
               void'(expq.pop_front());
            end else begin
               void'(expq.pop_front());
            end
            rcvd++;
         end
         if (req_fire) begin
            expq.push_back(ref_gcd(xif.req_msg[2*NB-1:NB], xif.req_msg[NB-1:0]));
            sent++;
         end
         if (req_fire && resp_fire) b2b++;
         @(posedge clk);
         #1;
         if (req_fire) begin
            xif.req_val = 1'b0;
            src_dly = $urandom_range(0, 3);
         end
         if (resp_fire) snk_dly = $urandom_range(0, 3);
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL stream_data: %0d wrong responses required 0", bad);
      end
      checks++;
      if (rcvd !== 1000 || sent !== 1000) begin
         errors++;
         $display("FAIL stream_count: sent %0d received %0d required 1000 each",
                  sent, rcvd);
      end
      checks++;
      if (b2b == 0) begin
         errors++;
         $display("FAIL stream_b2b: %0d same-edge accepts required >0", b2b);
      end
      xif.resp_rdy = 1'b1;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      reset  = 1'b0;
      test_reset();
      test_latency();
      test_boundaries();
      test_backpressure();
      test_reset_abort();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
